// File: rtl/fwd.sv
// Forwarding select type shared by the hazard controller and the EX-stage operand muxes.
package fwd;

  typedef enum logic {
    no_fwd  = 1'b0,
    use_fwd = 1'b1
  } fwd_sel_t;

endpackage

// File: rtl/fwd_hazard_ctrl.sv
// fwd_hazard_ctrl: operand-forwarding and load-use hazard control for a 5-stage pipeline.
// Tracks EX/MEM/WB shadow copies of in-flight instructions and produces forward selects for
// the EX-stage instruction, plus a load-use stall request with a saturating event counter.
//   clk, rst (async, active-low)
//   stall_in        global freeze, all state holds
//   flush           squash the instruction in ID
//   id_*            ID-stage instruction and decode flags
//   alumuxN_fwd_sel_exmem/memwb  forward selects for EX operand N
//   load_use_stall  hold PC and IF/ID, bubble into EX
//   stall_count     number of load-use bubbles inserted
module fwd_hazard_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_in,
  input  logic             flush,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_regwrite,
  input  logic             id_is_load,
  output fwd::fwd_sel_t    alumux1_fwd_sel_exmem,
  output fwd::fwd_sel_t    alumux2_fwd_sel_exmem,
  output fwd::fwd_sel_t    alumux1_fwd_sel_memwb,
  output fwd::fwd_sel_t    alumux2_fwd_sel_memwb,
  output logic             load_use_stall,
  output logic [CNT_W-1:0] stall_count
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
  } ex_slot_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
    logic       is_load;
  } mem_slot_t;

  // WB forwards loads and non-loads alike, so is_load is not carried past MEM.
  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       regwrite;
  } wb_slot_t;

  ex_slot_t         r_ex;
  mem_slot_t        r_mem;
  wb_slot_t         r_wb;
  logic [CNT_W-1:0] r_stall_count;

  logic     w_load_use;
  logic     w_mem_src;
  logic     w_wb_src;
  ex_slot_t w_ex_next;

  always_comb begin
    w_load_use = id_valid && !flush && r_ex.valid && r_ex.is_load && (r_ex.rd != '0) &&
                 ((id_uses_rs1 && (id_rs1 == r_ex.rd)) ||
                  (id_uses_rs2 && (id_rs2 == r_ex.rd)));

    // A load still in MEM has no data yet; that case is covered by the load-use stall.
    w_mem_src = r_mem.valid && r_mem.regwrite && !r_mem.is_load && (r_mem.rd != '0);
    w_wb_src  = r_wb.valid && r_wb.regwrite && (r_wb.rd != '0);

    alumux1_fwd_sel_exmem = fwd::no_fwd;
    alumux2_fwd_sel_exmem = fwd::no_fwd;
    alumux1_fwd_sel_memwb = fwd::no_fwd;
    alumux2_fwd_sel_memwb = fwd::no_fwd;
    if (w_mem_src && (r_mem.rd == r_ex.rs1)) alumux1_fwd_sel_exmem = fwd::use_fwd;
    if (w_mem_src && (r_mem.rd == r_ex.rs2)) alumux2_fwd_sel_exmem = fwd::use_fwd;
    if (w_wb_src  && (r_wb.rd  == r_ex.rs1)) alumux1_fwd_sel_memwb = fwd::use_fwd;
    if (w_wb_src  && (r_wb.rd  == r_ex.rs2)) alumux2_fwd_sel_memwb = fwd::use_fwd;

    w_ex_next = '0;
    if (id_valid && !flush && !w_load_use) begin
      w_ex_next.valid    = 1'b1;
      w_ex_next.rs1      = id_rs1;
      w_ex_next.rs2      = id_rs2;
      w_ex_next.rd       = id_rd;
      w_ex_next.regwrite = id_regwrite;
      w_ex_next.is_load  = id_is_load;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ex          <= '0;
      r_mem         <= '0;
      r_wb          <= '0;
      r_stall_count <= '0;
    end else if (!stall_in) begin
      r_wb.valid     <= r_mem.valid;
      r_wb.rd        <= r_mem.rd;
      r_wb.regwrite  <= r_mem.regwrite;
      r_mem.valid    <= r_ex.valid;
      r_mem.rd       <= r_ex.rd;
      r_mem.regwrite <= r_ex.regwrite;
      r_mem.is_load  <= r_ex.is_load;
      r_ex           <= w_ex_next;
      if (w_load_use && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + CNT_W'(1);
      end
    end
  end

  assign load_use_stall = w_load_use;
  assign stall_count    = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
module tb_fwd_hazard_ctrl;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          stall_in = 1'b0;
  logic          flush = 1'b0;
  logic          id_valid = 1'b0;
  logic [4:0]    id_rs1 = '0;
  logic [4:0]    id_rs2 = '0;
  logic [4:0]    id_rd = '0;
  logic          id_uses_rs1 = 1'b0;
  logic          id_uses_rs2 = 1'b0;
  logic          id_regwrite = 1'b0;
  logic          id_is_load = 1'b0;
  fwd::fwd_sel_t alumux1_fwd_sel_exmem;
  fwd::fwd_sel_t alumux2_fwd_sel_exmem;
  fwd::fwd_sel_t alumux1_fwd_sel_memwb;
  fwd::fwd_sel_t alumux2_fwd_sel_memwb;
  logic          load_use_stall;
  logic [15:0]   stall_count;

  int n_cmp = 0;
  int n_bad = 0;

  fwd_hazard_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_regwrite(id_regwrite), .id_is_load(id_is_load),
    .alumux1_fwd_sel_exmem(alumux1_fwd_sel_exmem), .alumux2_fwd_sel_exmem(alumux2_fwd_sel_exmem),
    .alumux1_fwd_sel_memwb(alumux1_fwd_sel_memwb), .alumux2_fwd_sel_memwb(alumux2_fwd_sel_memwb),
    .load_use_stall(load_use_stall), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Reference model: list of in-flight instructions, index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit v;
    int rs1;
    int rs2;
    int rd;
    bit rw;
    bit ld;
  } instr_t;

  instr_t pipe[3];
  int     m_count;

  function automatic instr_t bubble();
    instr_t b;
    b = '{v: 0, rs1: 0, rs2: 0, rd: 0, rw: 0, ld: 0};
    return b;
  endfunction

  task automatic m_clear();
    for (int unsigned i = 0; i < 3; i++) pipe[i] = bubble();
    m_count = 0;
  endtask

  // ID reads a register that a load in EX has not produced yet.
  function automatic bit m_lus();
    instr_t p;
    p = pipe[0];
    if (!id_valid || flush || !p.v || !p.ld || p.rd == 0) return 0;
    return (id_uses_rs1 && int'(id_rs1) == p.rd) || (id_uses_rs2 && int'(id_rs2) == p.rd);
  endfunction

  // Producer older than EX (1 = MEM, 2 = WB) supplies register rs to the EX instruction.
  function automatic bit m_fwd(int unsigned stage, int rs);
    instr_t p;
    p = pipe[stage];
    if (!p.v || !p.rw || p.rd == 0 || p.rd != rs) return 0;
    if (stage == 1 && p.ld) return 0;
    return 1;
  endfunction

  function automatic fwd::fwd_sel_t to_sel(bit b);
    return b ? fwd::use_fwd : fwd::no_fwd;
  endfunction

  task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                        input bit u1, input bit u2, input bit rw, input bit ld);
    id_valid    = v;
    id_rs1      = 5'(rs1);
    id_rs2      = 5'(rs2);
    id_rd       = 5'(rd);
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_regwrite = rw;
    id_is_load  = ld;
  endtask

  task automatic tick();
    bit     lus;
    instr_t n;
    lus = m_lus();
    n = '{v: 1, rs1: int'(id_rs1), rs2: int'(id_rs2), rd: int'(id_rd), rw: id_regwrite, ld: id_is_load};
    @(posedge clk);
    if (rst && !stall_in) begin
      if (lus && m_count < 65535) m_count++;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (id_valid && !flush && !lus) ? n : bubble();
    end
    #1;
  endtask

  task automatic do_reset();
    stall_in = 1'b0;
    flush    = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    m_clear();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    set_id(1, 0, 0, 0, 1, 1, 1, 0);
    #1;
    n_cmp++;
    if (load_use_stall !== 1'b0 || stall_count !== 16'd0) begin
      n_bad++;
      $display("FAIL reset_state: stall=%b count=%0d, want 0/0", load_use_stall, stall_count);
    end
    n_cmp++;
    if (alumux1_fwd_sel_exmem !== fwd::no_fwd || alumux2_fwd_sel_exmem !== fwd::no_fwd ||
        alumux1_fwd_sel_memwb !== fwd::no_fwd || alumux2_fwd_sel_memwb !== fwd::no_fwd) begin
      n_bad++;
      $display("FAIL reset_fwd: sels=%b%b%b%b, want 0000", alumux1_fwd_sel_exmem,
               alumux2_fwd_sel_exmem, alumux1_fwd_sel_memwb, alumux2_fwd_sel_memwb);
    end
  endtask

  task automatic test_exmem_fwd();
    do_reset();
    set_id(1, 1, 2, 5, 1, 1, 1, 0);  // add x5,x1,x2
    tick();
    set_id(1, 5, 1, 6, 1, 1, 1, 0);  // add x6,x5,x1
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (alumux1_fwd_sel_exmem !== fwd::use_fwd || alumux1_fwd_sel_memwb !== fwd::no_fwd) begin
      n_bad++;
      $display("FAIL b2b_exmem: exmem1=%b memwb1=%b, want 1/0", alumux1_fwd_sel_exmem, alumux1_fwd_sel_memwb);
    end
    n_cmp++;
    if (alumux2_fwd_sel_exmem !== fwd::no_fwd || load_use_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_rs2: exmem2=%b stall=%b, want 0/0", alumux2_fwd_sel_exmem, load_use_stall);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 1, 0, 7, 1, 0, 1, 1);  // lw x7,0(x1)
    tick();
    set_id(1, 1, 7, 8, 1, 1, 1, 0);  // add x8,x1,x7
    @(negedge clk);
    n_cmp++;
    if (load_use_stall !== 1'b1 || stall_count !== 16'd0) begin
      n_bad++;
      $display("FAIL lu_detect: stall=%b count=%0d, want 1/0", load_use_stall, stall_count);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (load_use_stall !== 1'b0 || stall_count !== 16'd1) begin
      n_bad++;
      $display("FAIL lu_bubble: stall=%b count=%0d, want 0/1", load_use_stall, stall_count);
    end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (alumux2_fwd_sel_memwb !== fwd::use_fwd || alumux2_fwd_sel_exmem !== fwd::no_fwd) begin
      n_bad++;
      $display("FAIL lu_fwd: memwb2=%b exmem2=%b, want 1/0", alumux2_fwd_sel_memwb, alumux2_fwd_sel_exmem);
    end
  endtask

  task automatic test_stall_in();
    do_reset();
    set_id(1, 1, 0, 7, 1, 0, 1, 1);
    tick();
    set_id(1, 7, 2, 8, 1, 1, 1, 0);
    stall_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (load_use_stall !== 1'b1 || stall_count !== 16'd0) begin
        n_bad++;
        $display("FAIL frozen_%0d: stall=%b count=%0d, want 1/0", i, load_use_stall, stall_count);
      end
      tick();
    end
    stall_in = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (load_use_stall !== 1'b0 || stall_count !== 16'd1) begin
      n_bad++;
      $display("FAIL unfrozen: stall=%b count=%0d, want 0/1", load_use_stall, stall_count);
    end
  endtask

  task automatic test_x0();
    do_reset();
    set_id(1, 1, 2, 0, 1, 1, 1, 0);  // add x0,x1,x2
    tick();
    set_id(1, 0, 0, 9, 1, 1, 1, 0);
    tick();
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (alumux1_fwd_sel_exmem !== fwd::no_fwd || alumux2_fwd_sel_exmem !== fwd::no_fwd ||
        alumux1_fwd_sel_memwb !== fwd::no_fwd || alumux2_fwd_sel_memwb !== fwd::no_fwd) begin
      n_bad++;
      $display("FAIL x0_fwd: sels=%b%b%b%b, want 0000", alumux1_fwd_sel_exmem,
               alumux2_fwd_sel_exmem, alumux1_fwd_sel_memwb, alumux2_fwd_sel_memwb);
    end
  endtask

  task automatic test_double_fwd();
    do_reset();
    set_id(1, 1, 2, 3, 1, 1, 1, 0);  // add x3
    tick();
    tick();                          // add x3 again
    set_id(1, 3, 3, 4, 1, 1, 1, 0);
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    n_cmp++;
    if (alumux1_fwd_sel_exmem !== fwd::use_fwd || alumux2_fwd_sel_exmem !== fwd::use_fwd ||
        alumux1_fwd_sel_memwb !== fwd::use_fwd || alumux2_fwd_sel_memwb !== fwd::use_fwd) begin
      n_bad++;
      $display("FAIL double_fwd: sels=%b%b%b%b, want 1111", alumux1_fwd_sel_exmem,
               alumux2_fwd_sel_exmem, alumux1_fwd_sel_memwb, alumux2_fwd_sel_memwb);
    end
  endtask

  task automatic test_flush_reset();
    do_reset();
    set_id(1, 1, 0, 7, 1, 0, 1, 1);  // lw x7
    tick();
    set_id(1, 7, 0, 10, 1, 0, 1, 1); // lw x10,0(x7), squashed
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (load_use_stall !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_mask: stall=%b, want 0", load_use_stall);
    end
    tick();
    flush = 1'b0;
    set_id(1, 10, 0, 11, 1, 0, 1, 0); // would stall only if x10 load entered EX
    @(negedge clk);
    n_cmp++;
    if (load_use_stall !== 1'b0 || stall_count !== 16'd0) begin
      n_bad++;
      $display("FAIL flush_bubble: stall=%b count=%0d, want 0/0", load_use_stall, stall_count);
    end
    do_reset();
    set_id(1, 1, 2, 3, 1, 1, 1, 0);  // add x3
    tick();
    set_id(1, 3, 0, 7, 1, 0, 1, 1);  // lw x7,0(x3)
    tick();
    set_id(1, 7, 0, 8, 1, 0, 1, 0);
    stall_in = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (load_use_stall !== 1'b1 || alumux1_fwd_sel_exmem !== fwd::use_fwd) begin
      n_bad++;
      $display("FAIL pre_rst: stall=%b exmem1=%b, want 1/1", load_use_stall, alumux1_fwd_sel_exmem);
    end
    #1 rst = 1'b0;
    m_clear();
    #1;
    n_cmp++;
    if (load_use_stall !== 1'b0 || alumux1_fwd_sel_exmem !== fwd::no_fwd || stall_count !== 16'd0) begin
      n_bad++;
      $display("FAIL mid_rst: stall=%b exmem1=%b count=%0d, want 0/0/0",
               load_use_stall, alumux1_fwd_sel_exmem, stall_count);
    end
    @(negedge clk);
    rst = 1'b1;
    stall_in = 1'b0;
    tick();
    @(negedge clk);
    n_cmp++;
    if (load_use_stall !== 1'b0 || stall_count !== 16'd0) begin
      n_bad++;
      $display("FAIL post_rst: stall=%b count=%0d, want 0/0", load_use_stall, stall_count);
    end
  endtask

  task automatic test_random();
    bit pulse;
    do_reset();
    tick();
    for (int cyc = 0; cyc < 400; cyc++) begin
      set_id($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 1),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      stall_in = ($urandom_range(0, 4) == 0);
      flush    = ($urandom_range(0, 9) == 0);
      pulse    = ($urandom_range(0, 59) == 0);
      if (pulse) begin
        rst = 1'b0;
        m_clear();
      end
      @(negedge clk);
      n_cmp++;
      if (load_use_stall !== m_lus() || stall_count !== 16'(m_count)) begin
        n_bad++;
        $display("FAIL rnd_stall c%0d: stall=%b count=%0d, want %b/%0d",
                 cyc, load_use_stall, stall_count, m_lus(), m_count);
      end
      if (pipe[0].v) begin
        n_cmp++;
        if (alumux1_fwd_sel_exmem !== to_sel(m_fwd(1, pipe[0].rs1)) ||
            alumux2_fwd_sel_exmem !== to_sel(m_fwd(1, pipe[0].rs2)) ||
            alumux1_fwd_sel_memwb !== to_sel(m_fwd(2, pipe[0].rs1)) ||
            alumux2_fwd_sel_memwb !== to_sel(m_fwd(2, pipe[0].rs2))) begin
          n_bad++;
          $display("FAIL rnd_fwd c%0d: sels=%b%b%b%b, want %b%b%b%b", cyc,
                   alumux1_fwd_sel_exmem, alumux2_fwd_sel_exmem,
                   alumux1_fwd_sel_memwb, alumux2_fwd_sel_memwb,
                   m_fwd(1, pipe[0].rs1), m_fwd(1, pipe[0].rs2),
                   m_fwd(2, pipe[0].rs1), m_fwd(2, pipe[0].rs2));
        end
      end
      if (pulse) begin
        #1 rst = 1'b1;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_exmem_fwd();
    test_load_use();
    test_stall_in();
    test_x0();
    test_double_fwd();
    test_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the load-use stall event counter.
REQ-002 SHALL have input clk, 1 bit: single clock; all state updates on the rising edge.
REQ-003 SHALL have input rst, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have input stall_in, 1 bit: global pipeline freeze (cache miss); all state holds while 1.
REQ-005 SHALL have input flush, 1 bit: taken branch/jump; the instruction currently in ID is squashed.
REQ-006 SHALL have input id_valid, 1 bit: ID stage holds a real instruction.
REQ-007 SHALL have inputs id_rs1, id_rs2, id_rd, 5 bits each: ID-stage register specifiers.
REQ-008 SHALL have inputs id_uses_rs1, id_uses_rs2, id_regwrite, id_is_load, 1 bit each: ID-stage decode flags.
REQ-009 SHALL have outputs alumux1_fwd_sel_exmem, alumux2_fwd_sel_exmem, alumux1_fwd_sel_memwb, alumux2_fwd_sel_memwb, type fwd::fwd_sel_t: operand forward selects for the EX-stage instruction.
REQ-010 SHALL have output load_use_stall, 1 bit: hold PC and IF/ID, insert bubble into EX.
REQ-011 SHALL have output stall_count, CNT_W bits: number of load-use bubbles inserted.

Function
REQ-012 SHALL keep shadow registers for EX, MEM, WB slots, each holding valid, rs1, rs2, rd, regwrite, is_load (rs fields used in EX slot only).
REQ-013 SHALL, on a clock edge with stall_in=1, hold all shadow registers and stall_count unchanged.
REQ-014 SHALL, on a clock edge with stall_in=0, shift WB<=MEM and MEM<=EX.
REQ-015 SHALL, in the same edge, load EX from ID fields when id_valid=1, flush=0, load_use_stall=0; otherwise load EX as bubble (valid=0, regwrite=0, rd=0).
REQ-016 SHALL assert load_use_stall combinationally when id_valid=1, flush=0, EX.valid=1, EX.is_load=1, EX.rd!=0, and (id_uses_rs1 and id_rs1==EX.rd, or id_uses_rs2 and id_rs2==EX.rd).
REQ-017 SHALL keep load_use_stall asserted (not masked) while stall_in=1; bubble insertion and counting occur only on the edge where stall_in=0.
REQ-018 SHALL drive alumuxN_fwd_sel_exmem=use_fwd when MEM.valid, MEM.regwrite, !MEM.is_load, MEM.rd!=0, MEM.rd==EX.rsN; else no_fwd (N=1 uses rs1, N=2 uses rs2).
REQ-019 SHALL drive alumuxN_fwd_sel_memwb=use_fwd when WB.valid, WB.regwrite, WB.rd!=0, WB.rd==EX.rsN; else no_fwd; both selects may be use_fwd simultaneously (EX stage gives exmem priority).
REQ-020 SHALL never forward for register x0.
REQ-021 SHALL increment stall_count by 1 on each stall_in=0 edge where load_use_stall=1, saturating at all-ones.
REQ-022 SHALL give flush priority over load-use: flush=1 forces load_use_stall=0 and an EX bubble.
REQ-023 SHALL compute forward selects and load_use_stall combinationally from current shadow state and ID inputs (zero latency); all other state is registered.

Reset
REQ-024 SHALL, while rst=0, asynchronously clear all shadow slots to bubbles and stall_count to 0.
REQ-025 SHALL, during and immediately after reset, drive all fwd selects no_fwd and load_use_stall 0.
REQ-026 SHALL, on reset asserted mid-stall, discard the pending bubble/count with no further effect.

Verification
REQ-027 SHALL pass: add x5 then add x6,x5,x1 back-to-back -> next cycle alumux1_fwd_sel_exmem=use_fwd, memwb=no_fwd.
REQ-028 SHALL pass: lw x7 then add x8,x1,x7 -> load_use_stall=1 one cycle, stall_count 0->1, then alumux2_fwd_sel_memwb=use_fwd, exmem=no_fwd.
REQ-029 SHALL pass: lw x7 dependency with stall_in=1 for 3 cycles -> load_use_stall held 3 cycles, stall_count increments once only after stall_in drops.
REQ-030 SHALL pass: add x0,x1,x2 followed by consumer of x0 -> all fwd selects no_fwd.
REQ-031 SHALL pass: add x3 in MEM and WB (back-to-back writes to x3), consumer reads x3 -> both exmem and memwb selects use_fwd.
REQ-032 SHALL pass: load-use hazard coincident with flush=1 -> load_use_stall=0, EX bubble, stall_count unchanged; rst=0 pulse mid-sequence -> all outputs cleared immediately.
